// File: rtl/tx_rd_req_tlp_gen_pkg.sv
// Shared constants, state encoding and header helper for the MRd64 generator.
// Used by tx_rd_req_tlp_gen; TX_RD_REQ_SPLIT_EN selects the split-chunk variant.
package tx_rd_req_tlp_gen_pkg;

    localparam logic [6:0]  FMT_TYPE_MRD64 = 7'b010_0000;
    localparam logic [9:0]  LEN_FULL       = 10'h080;
    localparam logic [9:0]  LEN_HALF       = 10'h040;
    localparam logic [63:0] SPLIT_OFFSET   = 64'h100;

    typedef enum logic [6:0] {
        IDLE     = 7'b000_0001,
        WAIT_BUF = 7'b000_0010,
        WAIT_GNT = 7'b000_0100,
        HDR0     = 7'b000_1000,
        HDR1     = 7'b001_0000,
        ACK      = 7'b010_0000,
        COOL     = 7'b100_0000
    } state_e;

    // DW0: R, fmt/type, R, TC, R, TD, EP, attr, R, length
    function automatic logic [31:0] mrd_dw0(input logic [9:0] len);
        return {1'b0, FMT_TYPE_MRD64, 1'b0, 3'b000, 4'h0,
                1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction

endpackage

// File: rtl/tx_rd_req_tlp_gen.sv
// Issues MRd64 read-request TLPs on the TRN TX bus, one 512-byte chunk per request.
// Define TX_RD_REQ_SPLIT_EN to send each chunk as two 64-DW reads instead of one.
module tx_rd_req_tlp_gen
    import tx_rd_req_tlp_gen_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    input  logic [15:0] cfg_completer_id,
    input  logic [3:0]  trn_tbuf_av,
    output logic        tx_req,
    input  logic        tx_grant,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n
);

    state_e           state;
    state_e           state_nxt;
    logic [63:0]      addr_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             last_tlp;
    logic [9:0]       len;
    logic [63:0]      cur_addr;
    logic [31:0]      dw0;
    logic [31:0]      dw1;
    logic [31:0]      dw2;
    logic [31:0]      dw3;
    logic             unused_tbuf;

    assign unused_tbuf    = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};
    assign trn_trem_n     = 8'h00;
    assign trn_tsrc_dsc_n = 1'b1;
    assign accept         = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

`ifdef TX_RD_REQ_SPLIT_EN
    logic second_q;

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            second_q <= 1'b0;
        end else if (state == HDR1 && accept) begin
            second_q <= !second_q;
        end
    end

    assign last_tlp = second_q;
    assign len      = LEN_HALF;
    assign cur_addr = second_q ? addr_q + SPLIT_OFFSET : addr_q;
`else
    assign last_tlp = 1'b1;
    assign len      = LEN_FULL;
    assign cur_addr = addr_q;
`endif

    assign dw0 = mrd_dw0(len);
    assign dw1 = {cfg_completer_id, 8'(tag_q), 4'hF, 4'hF};
    assign dw2 = cur_addr[63:32];
    assign dw3 = cur_addr[31:0] & 32'hFFFF_FFFC;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (read_chunk) state_nxt = WAIT_BUF;
            WAIT_BUF: if (trn_tbuf_av[1]) state_nxt = WAIT_GNT;
            WAIT_GNT: if (tx_grant) state_nxt = HDR0;
            HDR0:     if (accept) state_nxt = HDR1;
            HDR1:     if (accept) state_nxt = last_tlp ? ACK : WAIT_BUF;
            ACK:      state_nxt = COOL;
            COOL:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they hold under backpressure.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            tag_q          <= '0;
            read_chunk_ack <= 1'b0;
            tx_req         <= 1'b0;
            trn_td         <= '0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && read_chunk) begin
                addr_q <= huge_page_addr_read_from;
            end
            if (state == HDR1 && accept) begin
                tag_q <= tag_q + TAG_W'(1);
            end
            read_chunk_ack <= (state_nxt == ACK);
            tx_req         <= (state_nxt == WAIT_GNT) ||
                              (state_nxt == HDR0) ||
                              (state_nxt == HDR1);
            trn_tsof_n     <= (state_nxt != HDR0);
            trn_teof_n     <= (state_nxt != HDR1);
            trn_tsrc_rdy_n <= !((state_nxt == HDR0) ||
                                (state_nxt == HDR1));
            if (state_nxt == HDR0) begin
                trn_td <= {dw0, dw1};
            end else if (state_nxt == HDR1) begin
                trn_td <= {dw2, dw3};
            end else begin
                trn_td <= '0;
            end
        end
    end

endmodule
